addsub_seq: RTL

Parametrised, multi-cycle add/subtract unit with ARM-style NZCV flag generation, the successor to the single-cycle 32-bit subtractor in the ALU. Operands are processed CHUNK bits per clock through a registered carry chain, trading latency for a short critical path at any WIDTH. It supports ADD/SUB/ADC/SBC/RSB/CMP/CMN, so one block replaces separate adder and subtractor instances. A start/done handshake lets the ALU sequencer wait on a busy flag.

---
 rtl/addsub_seq.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/addsub_seq.sv
// Multi-cycle add/subtract unit with NZCV flags: CHUNK bits per clock through a
// registered carry, start/done handshake, results held until the next completion.
module addsub_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             s,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       flag_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       new_flag,
  output logic             write_en
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_ADC = 3'd2;
  localparam logic [2:0] OP_SBC = 3'd3;
  localparam logic [2:0] OP_RSB = 3'd4;
  localparam logic [2:0] OP_CMP = 3'd5;
  localparam logic [2:0] OP_CMN = 3'd6;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [KW-1:0]    k_q, k_d;
  logic [2:0]       op_q, op_d;
  logic             s_q, s_d;
  logic [3:0]       flag_q, flag_d;
  logic             x_msb_q, x_msb_d, y_msb_q, y_msb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       new_flag_q, new_flag_d;
  logic             write_en_q, write_en_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic [CHUNK:0]   chunk_sum_s;
  logic [WIDTH-1:0] sum_ext_s, acc_next_s;
  logic [3:0]       nzcv_s;
  logic             upd_s;

  // Chunk adder, operand loading and FSM next-state
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    acc_d      = acc_q;
    carry_d    = carry_q;
    k_d        = k_q;
    op_d       = op_q;
    s_d        = s_q;
    flag_d     = flag_q;
    x_msb_d    = x_msb_q;
    y_msb_d    = y_msb_q;
    result_d   = result_q;
    new_flag_d = new_flag_q;
    write_en_d = write_en_q;

    chunk_sum_s = {1'b0, x_q[CHUNK-1:0]} + {1'b0, y_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
    sum_ext_s = '0;
    sum_ext_s[CHUNK-1:0] = chunk_sum_s[CHUNK-1:0];
    // The accumulator fills from the top, so after N chunks it holds the full sum
    acc_next_s = (acc_q >> CHUNK) | (sum_ext_s << (WIDTH - CHUNK));
    nzcv_s[3] = acc_next_s[WIDTH-1];
    nzcv_s[2] = (acc_next_s == '0);
    nzcv_s[1] = chunk_sum_s[CHUNK];
    nzcv_s[0] = (x_msb_q == y_msb_q) && (acc_next_s[WIDTH-1] != x_msb_q);
    upd_s = s_q || (op_q == OP_CMP) || (op_q == OP_CMN);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          op_d    = op;
          s_d     = s;
          flag_d  = flag_in;
          acc_d   = '0;
          k_d     = '0;
          case (op)
            OP_SUB, OP_CMP: begin
              x_d = a;  y_d = ~b;  carry_d = 1'b1;
            end
            OP_ADC: begin
              x_d = a;  y_d = b;   carry_d = flag_in[1];
            end
            OP_SBC: begin
              x_d = a;  y_d = ~b;  carry_d = flag_in[1];
            end
            OP_RSB: begin
              x_d = b;  y_d = ~a;  carry_d = 1'b1;
            end
            default: begin
              x_d = a;  y_d = b;   carry_d = 1'b0;
            end
          endcase
          x_msb_d = x_d[WIDTH-1];
          y_msb_d = y_d[WIDTH-1];
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        x_d     = x_q >> CHUNK;
        y_d     = y_q >> CHUNK;
        acc_d   = acc_next_s;
        carry_d = chunk_sum_s[CHUNK];
        k_d     = k_q + KW'(1);
        if (k_q == KW'(N - 1)) begin
          state_d = DONE;
          if (op_q == 3'd7) begin
            result_d   = '0;
            new_flag_d = flag_q;
            write_en_d = 1'b0;
          end else begin
            result_d   = acc_next_s;
            new_flag_d = upd_s ? nzcv_s : flag_q;
            write_en_d = (op_q != OP_CMP) && (op_q != OP_CMN);
          end
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      acc_q      <= '0;
      carry_q    <= 1'b0;
      k_q        <= '0;
      op_q       <= 3'd0;
      s_q        <= 1'b0;
      flag_q     <= 4'd0;
      x_msb_q    <= 1'b0;
      y_msb_q    <= 1'b0;
      result_q   <= '0;
      new_flag_q <= 4'd0;
      write_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      acc_q      <= acc_d;
      carry_q    <= carry_d;
      k_q        <= k_d;
      op_q       <= op_d;
      s_q        <= s_d;
      flag_q     <= flag_d;
      x_msb_q    <= x_msb_d;
      y_msb_q    <= y_msb_d;
      result_q   <= result_d;
      new_flag_q <= new_flag_d;
      write_en_q <= write_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign new_flag = new_flag_q;
  assign write_en = write_en_q;

endmodule
